// File: rtl/piece_queue.sv
// Preview FIFO between the LFSR piece source and the spawn logic: detects fresh
// random codes, filters invalid/repeated codes and queues tetromino types for the game FSM.
module piece_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_REROLL = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [2:0]               randnum,
    input  logic                     piece_req,
    output logic                     piece_valid,
    output logic [2:0]               piece_type,
    output logic                     next_valid,
    output logic [2:0]               next_type,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underrun
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = (MAX_REROLL > 0) ? $clog2(MAX_REROLL + 1) : 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_prev;
    logic [2:0]      r_last;
    logic [RW-1:0]   r_reroll;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_underrun;
    logic [2:0]      r_mem [DEPTH];

    logic            w_new;
    logic            w_zero;
    logic            w_repeat;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_reroll;
    logic            w_underrun_set;
    logic [PW-1:0]   w_rd_next;

    // Candidate filter: a code is only examined in the cycle it first appears.
    assign w_new     = (randnum != r_prev);
    assign w_zero    = (randnum == 3'b000);
    assign w_repeat  = (randnum == r_last) && (r_reroll < RW'(MAX_REROLL));
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = piece_req && piece_valid;
    assign w_push    = w_new && !w_zero && !w_repeat && (!w_full || w_pop);
    assign w_reroll  = w_new && !w_zero && w_repeat;
    assign w_rd_next = r_rd_ptr + PW'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev     <= 3'b111;
            r_last     <= 3'b111;
            r_reroll   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_prev <= randnum;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_last   <= randnum;
                r_reroll <= '0;
            end else if (w_reroll) begin
                r_reroll <= r_reroll + RW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Storage is not reset; the valid flags gate every read.
    always_ff @(posedge Clk) begin
        if (!Reset && w_push) begin
            r_mem[r_wr_ptr] <= randnum - 3'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        piece_valid    = 1'b0;
        next_valid     = 1'b0;
        w_underrun_set = 1'b0;
        case (r_state)
            S_FILL: begin
                if (r_count == CW'(DEPTH)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                piece_valid    = (r_count >= CW'(1));
                next_valid     = (r_count >= CW'(2));
                w_underrun_set = (r_count == '0);
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    assign piece_type = piece_valid ? r_mem[r_rd_ptr]  : 3'd0;
    assign next_type  = next_valid  ? r_mem[w_rd_next] : 3'd0;
    assign count      = r_count;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: accepted piece types go into a scoreboard queue
// and are checked against the head/preview outputs and on every pop.
module tb_piece_queue;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] randnum;
    logic       piece_req;
    logic       piece_valid;
    logic [2:0] piece_type;
    logic       next_valid;
    logic [2:0] next_type;
    logic [2:0] count;
    logic       underrun;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [2:0]  sb [$];

    piece_queue dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .randnum     (randnum),
        .piece_req   (piece_req),
        .piece_valid (piece_valid),
        .piece_type  (piece_type),
        .next_valid  (next_valid),
        .next_type   (next_type),
        .count       (count),
        .underrun    (underrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic apply(input logic [2:0] val, input logic req);
        randnum   = val;
        piece_req = req;
        @(posedge Clk);
        #1;
        piece_req = 1'b0;
    endtask

    // Compare head/preview outputs with the scoreboard.
    task automatic chk_outputs(input string tag);
        logic [2:0] e_head;
        logic [2:0] e_next;
        e_head = (sb.size() >= 1) ? sb[0] : 3'd0;
        e_next = (sb.size() >= 2) ? sb[1] : 3'd0;
        chk({tag, "_valid"}, 8'(piece_valid), 8'(sb.size() >= 1));
        chk({tag, "_type"},  8'(piece_type),  8'(e_head));
        chk({tag, "_nvalid"}, 8'(next_valid), 8'(sb.size() >= 2));
        chk({tag, "_ntype"}, 8'(next_type),   8'(e_next));
        chk({tag, "_count"}, 8'(count),       8'(sb.size()));
    endtask

    // Pop with the source held: head must match the scoreboard before the edge.
    task automatic pop_hold(input logic [2:0] hold, input string tag);
        logic [2:0] e_head;
        e_head = (sb.size() >= 1) ? sb[0] : 3'd0;
        chk({tag, "_pophead"}, 8'(piece_type), 8'(e_head));
        apply(hold, 1'b1);
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    initial begin
        Reset     = 1'b1;
        randnum   = 3'b111;
        piece_req = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_valid", 8'(piece_valid), 8'd0);
        chk("rst_nvalid", 8'(next_valid), 8'd0);
        chk("rst_type", 8'(piece_type), 8'd0);
        chk("rst_ntype", 8'(next_type), 8'd0);
        chk("rst_underrun", 8'(underrun), 8'd0);

        // Fill: held 7 is not consumed, then 5,1,2,4 become types 4,0,1,3.
        apply(3'd7, 1'b0);
        chk("held7_count", 8'(count), 8'd0);
        apply(3'd5, 1'b0); sb.push_back(3'd4);
        apply(3'd1, 1'b0); sb.push_back(3'd0);
        apply(3'd2, 1'b0); sb.push_back(3'd1);
        apply(3'd4, 1'b0); sb.push_back(3'd3);
        chk("fill_count", 8'(count), 8'd4);
        chk("fill_notrun", 8'(piece_valid), 8'd0);
        apply(3'd4, 1'b0);
        chk_outputs("run");

        // Full without pop drops; full with pop pushes behind the rest.
        apply(3'd6, 1'b0);
        chk_outputs("drop");
        chk("pushpop_head", 8'(piece_type), 8'(sb[0]));
        apply(3'd5, 1'b1);
        void'(sb.pop_front());
        sb.push_back(3'd4);
        chk_outputs("pushpop");

        // Repeat rule with zeros in between (last pushed code is 5).
        pop_hold(3'd5, "p1");
        apply(3'd0, 1'b0);
        apply(3'd5, 1'b0);
        chk_outputs("rep_discard");
        apply(3'd0, 1'b0);
        apply(3'd5, 1'b0); sb.push_back(3'd4);
        chk_outputs("rep_accept");
        pop_hold(3'd5, "p2");
        apply(3'd0, 1'b0);
        apply(3'd5, 1'b0);
        chk_outputs("rep_cnt_cleared");
        apply(3'd6, 1'b0); sb.push_back(3'd5);
        chk_outputs("push6");

        // Drain to empty: underrun is sticky and empty pops are ignored.
        for (int i = 0; i < 4; i++) begin
            chk_outputs("drain");
            pop_hold(3'd6, "drain");
        end
        chk_outputs("empty");
        chk("underrun_pre", 8'(underrun), 8'd0);
        apply(3'd6, 1'b0);
        chk("underrun_set", 8'(underrun), 8'd1);
        apply(3'd6, 1'b1);
        chk("empty_pop_count", 8'(count), 8'd0);
        chk("underrun_sticky", 8'(underrun), 8'd1);
        apply(3'd3, 1'b0); sb.push_back(3'd2);
        chk_outputs("refill1");
        apply(3'd1, 1'b0); sb.push_back(3'd0);
        apply(3'd2, 1'b0); sb.push_back(3'd1);
        chk_outputs("three");
        chk("underrun_still", 8'(underrun), 8'd1);

        // Reset mid-run, then refill in FILL ignoring requests.
        Reset   = 1'b1;
        randnum = 3'b111;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        sb.delete();
        chk_outputs("mid_rst");
        chk("mid_rst_underrun", 8'(underrun), 8'd0);
        apply(3'd7, 1'b1);
        chk("fill_req_ignored", 8'(count), 8'd0);
        apply(3'd1, 1'b1); sb.push_back(3'd0);
        apply(3'd2, 1'b1); sb.push_back(3'd1);
        apply(3'd3, 1'b1); sb.push_back(3'd2);
        apply(3'd4, 1'b1); sb.push_back(3'd3);
        chk("refill_count", 8'(count), 8'd4);
        apply(3'd4, 1'b1);
        chk("fill_pop_ignored", 8'(count), 8'd4);
        chk_outputs("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
